// File: rtl/s_axil_regbank.sv
// AXI4-Lite slave register bank.
// Word indices 0..NUM_CTRL-1 are read/write control registers; indices
// NUM_CTRL..NUM_CTRL+NUM_STAT-1 are read-only status words sampled from stat_in_i
// when the read address is accepted. Any other index answers SLVERR.
// Ports:
//   axi_clock, rst          clock, synchronous active-high reset
//   s_axil_aw*/w*/b*        write address, write data and write response channels
//   s_axil_ar*/r*           read address and read data channels (prot ignored)
//   ctrl_regs_o             flat control image, reg k at [k*DATA_WIDTH +: DATA_WIDTH]
//   ctrl_wr_pulse_o         bit k high for one cycle when reg k is committed
//   stat_in_i               flat status words, word s at [s*DATA_WIDTH +: DATA_WIDTH]
module s_axil_regbank #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned NUM_CTRL   = 8,
  parameter int unsigned NUM_STAT   = 4,
  parameter logic [NUM_CTRL*DATA_WIDTH-1:0] CTRL_RST = '0
) (
  input  logic                           axi_clock,
  input  logic                           rst,
  input  logic [ADDR_WIDTH-1:0]          s_axil_awaddr_i,
  input  logic [2:0]                     s_axil_awprot_i,
  input  logic                           s_axil_awvalid_i,
  output logic                           s_axil_awready_o,
  input  logic [DATA_WIDTH-1:0]          s_axil_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]        s_axil_wstrb_i,
  input  logic                           s_axil_wvalid_i,
  output logic                           s_axil_wready_o,
  output logic [1:0]                     s_axil_bresp_o,
  output logic                           s_axil_bvalid_o,
  input  logic                           s_axil_bready_i,
  input  logic [ADDR_WIDTH-1:0]          s_axil_araddr_i,
  input  logic [2:0]                     s_axil_arprot_i,
  input  logic                           s_axil_arvalid_i,
  output logic                           s_axil_arready_o,
  output logic [DATA_WIDTH-1:0]          s_axil_rdata_o,
  output logic [1:0]                     s_axil_rresp_o,
  output logic                           s_axil_rvalid_o,
  input  logic                           s_axil_rready_i,
  output logic [NUM_CTRL*DATA_WIDTH-1:0] ctrl_regs_o,
  output logic [NUM_CTRL-1:0]            ctrl_wr_pulse_o,
  input  logic [NUM_STAT*DATA_WIDTH-1:0] stat_in_i
);

  localparam int unsigned StrbW   = DATA_WIDTH / 8;
  localparam int unsigned AddrLsb = $clog2(StrbW);
  localparam int unsigned IdxW    = ADDR_WIDTH - AddrLsb;
  localparam int unsigned NumRegs = NUM_CTRL + NUM_STAT;
  localparam logic [1:0]  RespOkay   = 2'b00;
  localparam logic [1:0]  RespSlvErr = 2'b10;

  logic                           aw_full_q, aw_full_d;
  logic [IdxW-1:0]                aw_idx_q, aw_idx_d;
  logic                           w_full_q, w_full_d;
  logic [DATA_WIDTH-1:0]          w_data_q, w_data_d;
  logic [StrbW-1:0]               w_strb_q, w_strb_d;
  logic                           bvalid_q, bvalid_d;
  logic [1:0]                     bresp_q, bresp_d;
  logic [NUM_CTRL*DATA_WIDTH-1:0] ctrl_q, ctrl_d;
  logic [NUM_CTRL-1:0]            pulse_q, pulse_d;
  logic                           rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0]          rdata_q, rdata_d;
  logic [1:0]                     rresp_q, rresp_d;

  logic        awready, wready, arready, commit;
  logic [31:0] aw_idx32, ar_idx32;

  assign awready = !aw_full_q && !bvalid_q;
  assign wready  = !w_full_q && !bvalid_q;
  assign arready = !rvalid_q;
  assign commit  = aw_full_q && w_full_q && !bvalid_q;

  // Write path: independent AW/W holding buffers, commit once both are full.
  always_comb begin
    aw_full_d = aw_full_q;
    aw_idx_d  = aw_idx_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    ctrl_d    = ctrl_q;
    pulse_d   = '0;
    aw_idx32  = '0;
    aw_idx32[IdxW-1:0] = aw_idx_q;

    if (awready && s_axil_awvalid_i) begin
      aw_full_d = 1'b1;
      aw_idx_d  = s_axil_awaddr_i[ADDR_WIDTH-1:AddrLsb];
    end
    if (wready && s_axil_wvalid_i) begin
      w_full_d = 1'b1;
      w_data_d = s_axil_wdata_i;
      w_strb_d = s_axil_wstrb_i;
    end

    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      if (aw_idx32 < NUM_CTRL) begin
        bresp_d = RespOkay;
        for (int unsigned k = 0; k < NUM_CTRL; k++) begin
          if (aw_idx32 == k) begin
            pulse_d[k] = 1'b1;
            for (int unsigned i = 0; i < StrbW; i++) begin
              if (w_strb_q[i]) begin
                ctrl_d[k*DATA_WIDTH + i*8 +: 8] = w_data_q[i*8 +: 8];
              end
            end
          end
        end
      end else begin
        bresp_d = RespSlvErr;
      end
    end else if (bvalid_q && s_axil_bready_i) begin
      bvalid_d = 1'b0;
    end
  end

  // Read path. Control reads use ctrl_d so a write committing on the same edge is visible.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    ar_idx32 = '0;
    ar_idx32[IdxW-1:0] = s_axil_araddr_i[ADDR_WIDTH-1:AddrLsb];

    if (arready && s_axil_arvalid_i) begin
      rvalid_d = 1'b1;
      rdata_d  = '0;
      rresp_d  = RespOkay;
      if (ar_idx32 < NUM_CTRL) begin
        for (int unsigned k = 0; k < NUM_CTRL; k++) begin
          if (ar_idx32 == k) rdata_d = ctrl_d[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end else if (ar_idx32 < NumRegs) begin
        for (int unsigned s = 0; s < NUM_STAT; s++) begin
          if (ar_idx32 == NUM_CTRL + s) rdata_d = stat_in_i[s*DATA_WIDTH +: DATA_WIDTH];
        end
      end else begin
        rresp_d = RespSlvErr;
      end
    end else if (rvalid_q && s_axil_rready_i) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge axi_clock) begin
    if (rst) begin
      aw_full_q <= 1'b0;
      aw_idx_q  <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RespOkay;
      ctrl_q    <= CTRL_RST;
      pulse_q   <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RespOkay;
    end else begin
      aw_full_q <= aw_full_d;
      aw_idx_q  <= aw_idx_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      ctrl_q    <= ctrl_d;
      pulse_q   <= pulse_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign s_axil_awready_o = awready;
  assign s_axil_wready_o  = wready;
  assign s_axil_bvalid_o  = bvalid_q;
  assign s_axil_bresp_o   = bresp_q;
  assign s_axil_arready_o = arready;
  assign s_axil_rvalid_o  = rvalid_q;
  assign s_axil_rdata_o   = rdata_q;
  assign s_axil_rresp_o   = rresp_q;
  assign ctrl_regs_o      = ctrl_q;
  assign ctrl_wr_pulse_o  = pulse_q;

  // Sub-word address bits and prot carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{s_axil_awprot_i, s_axil_arprot_i,
                       s_axil_awaddr_i[AddrLsb-1:0], s_axil_araddr_i[AddrLsb-1:0]};

endmodule

// File: tb/tb_s_axil_regbank.sv
// Self-checking bench for s_axil_regbank (32-bit data, 8 control, 4 status words).
module tb_s_axil_regbank;

  localparam logic [255:0] CtrlRst = {32'h7777_0007, 32'h6666_0006, 32'h5555_0005,
                                      32'h4444_0004, 32'h3333_0003, 32'h2222_0002,
                                      32'h1111_0001, 32'hA5A5_0001};

  logic         axi_clock = 1'b0;
  logic         rst;
  logic [7:0]   awaddr, araddr;
  logic [2:0]   awprot, arprot;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready;
  logic [31:0]  wdata, rdata;
  logic [3:0]   wstrb;
  logic [1:0]   bresp, rresp;
  logic [255:0] ctrl_regs;
  logic [7:0]   ctrl_wr_pulse;
  logic [127:0] stat_in;

  logic [31:0] ctrl_m [8];
  logic [31:0] stat_m [4];
  int n_checks = 0;
  int n_pass   = 0;

  assign stat_in = {stat_m[3], stat_m[2], stat_m[1], stat_m[0]};

  s_axil_regbank #(
    .DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_CTRL(8), .NUM_STAT(4), .CTRL_RST(CtrlRst)
  ) dut (
    .axi_clock        (axi_clock),
    .rst              (rst),
    .s_axil_awaddr_i  (awaddr),
    .s_axil_awprot_i  (awprot),
    .s_axil_awvalid_i (awvalid),
    .s_axil_awready_o (awready),
    .s_axil_wdata_i   (wdata),
    .s_axil_wstrb_i   (wstrb),
    .s_axil_wvalid_i  (wvalid),
    .s_axil_wready_o  (wready),
    .s_axil_bresp_o   (bresp),
    .s_axil_bvalid_o  (bvalid),
    .s_axil_bready_i  (bready),
    .s_axil_araddr_i  (araddr),
    .s_axil_arprot_i  (arprot),
    .s_axil_arvalid_i (arvalid),
    .s_axil_arready_o (arready),
    .s_axil_rdata_o   (rdata),
    .s_axil_rresp_o   (rresp),
    .s_axil_rvalid_o  (rvalid),
    .s_axil_rready_i  (rready),
    .ctrl_regs_o      (ctrl_regs),
    .ctrl_wr_pulse_o  (ctrl_wr_pulse),
    .stat_in_i        (stat_in)
  );

  always #5 axi_clock = ~axi_clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [255:0] ctrl_image();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = ctrl_m[k];
    return v;
  endfunction

  function automatic void model_reset();
    logic [255:0] r;
    r = CtrlRst;
    for (int k = 0; k < 8; k++) ctrl_m[k] = r[k*32 +: 32];
  endfunction

  // order: 0 AW+W together, 1 W first then AW after gap, 2 AW first then W after gap.
  // w_pre: W already sits in the slave's buffer (data/strb must match it).
  task automatic axil_write(input logic [7:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int order, input int gap,
                            input int bdelay, input bit w_pre);
    bit aw_done, w_done, aw_hs, w_hs;
    int cyc, lat, idx;
    logic [1:0] exp_resp;
    logic [7:0] exp_pulse;
    @(posedge axi_clock); #1;
    aw_done = 0; w_done = w_pre; cyc = 0;
    awaddr = addr; wdata = data; wstrb = strb;
    while (!(aw_done && w_done) && cyc < 50) begin
      awvalid = !aw_done && (order != 1 || cyc >= gap);
      wvalid  = !w_done && (order != 2 || cyc >= gap);
      @(negedge axi_clock);
      if (w_done && !aw_done) check_eq("wready_low_while_w_buffered", wready, 1'b0);
      if (aw_done && !w_done) check_eq("awready_low_while_aw_buffered", awready, 1'b0);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(posedge axi_clock); #1;
      aw_done |= aw_hs;
      w_done  |= w_hs;
      cyc++;
    end
    awvalid = 0; wvalid = 0;
    if (!(aw_done && w_done)) begin
      check_eq("write_accept_timeout", {aw_done, w_done}, 2'b11);
      return;
    end
    lat = 0;
    do begin
      @(negedge axi_clock);
      lat++;
    end while (!bvalid && lat < 20);
    check_eq("b_latency", lat, 2);
    if (!bvalid) return;
    idx = int'(addr >> 2);
    exp_pulse = '0;
    if (idx < 8) begin
      for (int i = 0; i < 4; i++) if (strb[i]) ctrl_m[idx][i*8 +: 8] = data[i*8 +: 8];
      exp_resp = 2'b00;
      exp_pulse[idx] = 1'b1;
    end else begin
      exp_resp = 2'b10;
    end
    check_eq("bresp", bresp, exp_resp);
    check_eq("wr_pulse_first_bvalid", ctrl_wr_pulse, exp_pulse);
    check_eq("ctrl_regs_after_commit", ctrl_regs, ctrl_image());
    for (int d = 0; d < bdelay; d++) begin
      @(negedge axi_clock);
      check_eq("bvalid_held", bvalid, 1'b1);
      check_eq("bresp_held", bresp, exp_resp);
      check_eq("awready_low_during_b", awready, 1'b0);
      check_eq("wready_low_during_b", wready, 1'b0);
      check_eq("no_second_pulse", ctrl_wr_pulse, 8'h00);
    end
    @(posedge axi_clock); #1;
    bready = 1;
    @(negedge axi_clock);
    check_eq("pulse_single_cycle", ctrl_wr_pulse, 8'h00);
    @(posedge axi_clock); #1;
    bready = 0;
    @(negedge axi_clock);
    check_eq("bvalid_clear_after_b", bvalid, 1'b0);
    check_eq("awready_after_b", awready, 1'b1);
    check_eq("wready_after_b", wready, 1'b1);
    check_eq("ctrl_regs_stable", ctrl_regs, ctrl_image());
  endtask

  task automatic axil_read(input logic [7:0] addr, input int rdelay);
    int cyc, idx;
    bit hs;
    logic [31:0] exp_data;
    logic [1:0] exp_resp;
    @(posedge axi_clock); #1;
    araddr = addr; arvalid = 1; cyc = 0;
    idx = int'(addr >> 2);
    if (idx < 8) begin
      exp_data = ctrl_m[idx]; exp_resp = 2'b00;
    end else if (idx < 12) begin
      exp_data = stat_m[idx-8]; exp_resp = 2'b00;
    end else begin
      exp_data = '0; exp_resp = 2'b10;
    end
    do begin
      @(negedge axi_clock);
      hs = arready;
      @(posedge axi_clock); #1;
      cyc++;
    end while (!hs && cyc < 20);
    arvalid = 0;
    check_eq("ar_accepted", hs, 1'b1);
    // Status is sampled at acceptance; later changes must not leak into rdata.
    for (int s = 0; s < 4; s++) stat_m[s] = $urandom;
    @(negedge axi_clock);
    check_eq("rvalid_latency1", rvalid, 1'b1);
    check_eq("rdata", rdata, exp_data);
    check_eq("rresp", rresp, exp_resp);
    for (int d = 0; d < rdelay; d++) begin
      @(negedge axi_clock);
      check_eq("rdata_held", {rvalid, rresp, rdata}, {1'b1, exp_resp, exp_data});
      check_eq("arready_low_during_r", arready, 1'b0);
    end
    @(posedge axi_clock); #1;
    rready = 1;
    @(posedge axi_clock); #1;
    rready = 0;
    @(negedge axi_clock);
    check_eq("rvalid_clear", rvalid, 1'b0);
    check_eq("arready_after_r", arready, 1'b1);
  endtask

  initial begin
    logic [7:0] a;
    rst = 1; awaddr = 0; araddr = 0; awprot = 3'b010; arprot = 3'b101;
    awvalid = 0; wvalid = 0; wdata = 0; wstrb = 0; bready = 0; arvalid = 0; rready = 0;
    for (int s = 0; s < 4; s++) stat_m[s] = 32'hC0DE_0000 + s;
    model_reset();
    repeat (3) @(posedge axi_clock);
    #1 rst = 0;

    // Reset state
    @(negedge axi_clock);
    check_eq("rst_ctrl_regs", ctrl_regs, CtrlRst);
    check_eq("rst_readies", {awready, wready, arready}, 3'b111);
    check_eq("rst_valids", {bvalid, rvalid}, 2'b00);
    check_eq("rst_resps_rdata", {bresp, rresp, rdata}, 36'h0);
    check_eq("rst_pulse", ctrl_wr_pulse, 8'h00);
    axil_read(8'h00, 0);

    // Single-cycle AW+W, then readback
    axil_write(8'h04, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0);
    axil_read(8'h04, 0);

    // W first, AW three cycles later, single byte strobe
    axil_write(8'h08, 32'h0000_00FF, 4'b0001, 1, 3, 0, 0);
    axil_read(8'h08, 1);

    // Back-pressured B, then a write right after
    axil_write(8'h0C, 32'h1357_9BDF, 4'b1010, 2, 2, 5, 0);
    axil_write(8'h1D, 32'hFEED_F00D, 4'b0110, 0, 0, 0, 0);

    // Status read and illegal status write
    stat_m[0] = 32'h1234_5678;
    axil_read(8'h20, 0);
    axil_write(8'h20, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, 0);
    axil_read(8'h22, 0);

    // Out-of-range read held by rready low
    axil_read(8'hFC, 3);

    // Reset with an AW buffered: the buffer is dropped, no response issued
    @(posedge axi_clock); #1;
    awaddr = 8'h10; awvalid = 1;
    @(posedge axi_clock); #1;
    awvalid = 0; rst = 1;
    @(posedge axi_clock); #1;
    rst = 0;
    model_reset();
    @(negedge axi_clock);
    check_eq("midrst_ctrl_regs", ctrl_regs, CtrlRst);
    check_eq("midrst_bvalid", bvalid, 1'b0);
    @(posedge axi_clock); #1;
    wdata = 32'hABCD_0123; wstrb = 4'hF; wvalid = 1;
    @(posedge axi_clock); #1;
    wvalid = 0;
    repeat (3) begin
      @(negedge axi_clock);
      check_eq("midrst_no_commit", bvalid, 1'b0);
      check_eq("midrst_aw_cleared", awready, 1'b1);
    end
    axil_write(8'h14, 32'hABCD_0123, 4'hF, 0, 0, 0, 1);

    // Randomized mix
    for (int n = 0; n < 40; n++) begin
      a = $urandom_range(0, 1) ? 8'($urandom_range(0, 47)) : 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1)
        axil_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2),
                   $urandom_range(0, 3), $urandom_range(0, 3), 0);
      else
        axil_read(a, $urandom_range(0, 3));
    end
    for (int k = 0; k < 8; k++) axil_read(8'(k*4), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
